// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mul_pkg;

  // Control states of the multiplier FSM.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMul    = 2'd1,
    StResult = 2'd2
  } state_e;

  // Full product width; wide enough that no operand pair can overflow.
  function automatic int unsigned prod_width(input int unsigned a_w, input int unsigned b_w);
    return a_w + b_w;
  endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/product handshake bundle for the shift-add multiplier.
interface seq_shift_add_multiplier_if #(
  parameter int unsigned A_W = 16,
  parameter int unsigned B_W = 8
) ();
  import mul_pkg::*;

  localparam int unsigned P_W = prod_width(A_W, B_W);

  logic           in_vld;
  logic           in_rdy;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic           out_vld;
  logic           out_rdy;
  logic [P_W-1:0] p;
  logic           busy;

  // Producer/consumer side.
  modport master (
    output in_vld, a, b, out_rdy,
    input  in_rdy, out_vld, p, busy
  );

  // Multiplier side.
  modport slave (
    input  in_vld, a, b, out_rdy,
    output in_rdy, out_vld, p, busy
  );

endinterface

// File: rtl/lsb_one_finder.sv
// Priority encoder returning the index of the lowest set bit of vec_i.
module lsb_one_finder #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]         vec_i,
  output logic [$clog2(W)-1:0] idx_o,
  output logic                 found_o
);

  localparam int unsigned IdxW = $clog2(W);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IdxW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential multiplier: one partial-product add per set bit of |b|, then a held result.
module seq_shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned A_W    = 16,
  parameter int unsigned B_W    = 8,
  parameter bit          SIGNED = 1'b0
) (
  input logic                        clk,
  input logic                        rst,
  seq_shift_add_multiplier_if.slave  bus
);

  localparam int unsigned P_W  = prod_width(A_W, B_W);
  localparam int unsigned IdxW = $clog2(B_W);

  state_e         state_q, state_d;
  logic [A_W-1:0] a_mag_q, a_mag_d;
  logic [B_W-1:0] b_rem_q, b_rem_d;
  logic [P_W-1:0] acc_q, acc_d;
  logic [P_W-1:0] p_q, p_d;
  logic           sign_q, sign_d;
  logic           out_vld_q, out_vld_d;

  logic           a_neg, b_neg;
  logic [A_W-1:0] a_mag;
  logic [B_W-1:0] b_mag;
  logic [IdxW-1:0] lsb_idx;
  logic           lsb_found;

  // Magnitudes; negating the most negative value wraps to 2^(W-1), which is exact unsigned.
  assign a_neg = SIGNED && bus.a[A_W-1];
  assign b_neg = SIGNED && bus.b[B_W-1];
  assign a_mag = a_neg ? (~bus.a + A_W'(1)) : bus.a;
  assign b_mag = b_neg ? (~bus.b + B_W'(1)) : bus.b;

  lsb_one_finder #(
    .W (B_W)
  ) u_lsb_one_finder (
    .vec_i   (b_rem_q),
    .idx_o   (lsb_idx),
    .found_o (lsb_found)
  );

  // Next-state and datapath update for the IDLE/MUL/RESULT sequence.
  always_comb begin
    state_d   = state_q;
    a_mag_d   = a_mag_q;
    b_rem_d   = b_rem_q;
    acc_d     = acc_q;
    sign_d    = sign_q;
    out_vld_d = out_vld_q;
    p_d       = p_q;
    case (state_q)
      StIdle: begin
        if (bus.in_vld) begin
          a_mag_d = a_mag;
          b_rem_d = b_mag;
          acc_d   = '0;
          sign_d  = a_neg ^ b_neg;
          state_d = (b_mag != '0) ? StMul : StResult;
        end
      end
      StMul: begin
        if (lsb_found) begin
          acc_d            = acc_q + (P_W'(a_mag_q) << lsb_idx);
          b_rem_d[lsb_idx] = 1'b0;
        end
        if (b_rem_d == '0) begin
          state_d = StResult;
        end
      end
      StResult: begin
        // First RESULT cycle registers the product; it is then held until consumed.
        if (!out_vld_q) begin
          out_vld_d = 1'b1;
          p_d       = sign_q ? (~acc_q + P_W'(1)) : acc_q;
        end else if (bus.out_rdy) begin
          out_vld_d = 1'b0;
          p_d       = '0;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      a_mag_q   <= '0;
      b_rem_q   <= '0;
      acc_q     <= '0;
      sign_q    <= 1'b0;
      out_vld_q <= 1'b0;
      p_q       <= '0;
    end else begin
      state_q   <= state_d;
      a_mag_q   <= a_mag_d;
      b_rem_q   <= b_rem_d;
      acc_q     <= acc_d;
      sign_q    <= sign_d;
      out_vld_q <= out_vld_d;
      p_q       <= p_d;
    end
  end

  assign bus.in_rdy  = (state_q == StIdle);
  assign bus.busy    = (state_q != StIdle);
  assign bus.out_vld = out_vld_q;
  assign bus.p       = p_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: unsigned and signed instances against an arithmetic model.
module tb_seq_shift_add_multiplier;

  localparam int unsigned A_W = 16;
  localparam int unsigned B_W = 8;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        in_vld;
  logic        out_rdy;
  logic [15:0] a;
  logic [7:0]  b;

  logic        o_in_rdy;
  logic        o_out_vld;
  logic        o_busy;
  logic [23:0] o_p;

  int n_checks;
  int n_pass;

  seq_shift_add_multiplier_if #(.A_W(A_W), .B_W(B_W)) u_if ();
  seq_shift_add_multiplier_if #(.A_W(A_W), .B_W(B_W)) s_if ();

  seq_shift_add_multiplier #(.A_W(A_W), .B_W(B_W), .SIGNED(1'b0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  seq_shift_add_multiplier #(.A_W(A_W), .B_W(B_W), .SIGNED(1'b1)) s_dut (
    .clk (clk),
    .rst (rst),
    .bus (s_if)
  );

  assign u_if.in_vld  = in_vld & ~sel;
  assign s_if.in_vld  = in_vld & sel;
  assign u_if.out_rdy = out_rdy & ~sel;
  assign s_if.out_rdy = out_rdy & sel;
  assign u_if.a = a;
  assign s_if.a = a;
  assign u_if.b = b;
  assign s_if.b = b;

  assign o_in_rdy  = sel ? s_if.in_rdy  : u_if.in_rdy;
  assign o_out_vld = sel ? s_if.out_vld : u_if.out_vld;
  assign o_busy    = sel ? s_if.busy    : u_if.busy;
  assign o_p       = sel ? s_if.p       : u_if.p;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product from plain integer arithmetic.
  function automatic logic [23:0] ref_prod(input bit sgn, input logic [15:0] av,
                                           input logic [7:0] bv);
    longint r;
    if (sgn) r = longint'($signed(av)) * longint'($signed(bv));
    else     r = longint'(av) * longint'(bv);
    return r[23:0];
  endfunction

  // Expected accept-to-out_vld latency: one cycle per set bit of |b|, plus one.
  function automatic int ref_lat(input bit sgn, input logic [7:0] bv);
    int bm;
    bm = (sgn && bv[7]) ? 256 - int'(bv) : int'(bv);
    return $countones(bm) + 1;
  endfunction

  // One full transaction: accept, latency/product check, held result, consume.
  task automatic do_op(input bit sgn, input logic [15:0] av, input logic [7:0] bv,
                       input int hold, input string tag);
    logic [23:0] exp_p;
    int exp_lat;
    int n;
    int g;
    sel = sgn;
    exp_p = ref_prod(sgn, av, bv);
    exp_lat = ref_lat(sgn, bv);
    g = 0;
    #0;
    while (!o_in_rdy && g < 50) begin
      @(posedge clk); #1; g++;
    end
    n_checks++;
    if (o_in_rdy !== 1'b1) $display("FAIL %s in_rdy_wait: got %b want 1", tag, o_in_rdy);
    else n_pass++;
    a = av; b = bv; in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0; a = 16'($urandom); b = 8'($urandom);
    n = 0;
    while (!o_out_vld && n < 30) begin
      @(posedge clk); #1; n++;
    end
    n_checks++;
    if (n !== exp_lat) $display("FAIL %s latency: got %0d want %0d", tag, n, exp_lat);
    else n_pass++;
    n_checks++;
    if (o_p !== exp_p) $display("FAIL %s product: got %h want %h", tag, o_p, exp_p);
    else n_pass++;
    // Held result under back-pressure, with a competing in_vld that must be ignored.
    for (int i = 0; i < hold; i++) begin
      in_vld = 1'b1; a = 16'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if (o_out_vld !== 1'b1 || o_p !== exp_p || o_in_rdy !== 1'b0)
        $display("FAIL %s hold%0d: vld=%b p=%h rdy=%b want vld=1 p=%h rdy=0",
                 tag, i, o_out_vld, o_p, o_in_rdy, exp_p);
      else n_pass++;
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    n_checks++;
    if (o_out_vld !== 1'b0 || o_p !== 24'h0 || o_in_rdy !== 1'b1 || o_busy !== 1'b0)
      $display("FAIL %s consume: vld=%b p=%h rdy=%b busy=%b want 0 000000 1 0",
               tag, o_out_vld, o_p, o_in_rdy, o_busy);
    else n_pass++;
    in_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; a = '0; b = '0; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      n_checks++;
      if (o_in_rdy !== 1'b1 || o_busy !== 1'b0 || o_out_vld !== 1'b0 || o_p !== 24'h0)
        $display("FAIL reset_state%0d: rdy=%b busy=%b vld=%b p=%h want 1 0 0 000000",
                 s, o_in_rdy, o_busy, o_out_vld, o_p);
      else n_pass++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    do_op(1'b0, 16'h1234, 8'h05, 0, "u_1234x05");
    do_op(1'b0, 16'hFFFF, 8'hFF, 0, "u_ffffxff");
    do_op(1'b0, 16'hABCD, 8'h00, 0, "u_b_zero");
    do_op(1'b1, 16'h8000, 8'h80, 0, "s_min_min");
    do_op(1'b1, 16'hFFFD, 8'h07, 0, "s_m3x7");
    do_op(1'b1, 16'h7FFF, 8'h80, 1, "s_max_min");
    do_op(1'b1, 16'h1234, 8'h00, 0, "s_b_zero");
  endtask

  task automatic test_backpressure();
    do_op(1'b0, 16'h00F3, 8'h21, 5, "u_hold5");
    do_op(1'b1, 16'hF00D, 8'hC3, 5, "s_hold5");
  endtask

  task automatic test_reset_mid();
    bit seen;
    sel = 1'b0;
    a = 16'd3; b = 8'h0F; in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_in_rdy !== 1'b1 || o_out_vld !== 1'b0 || o_p !== 24'h0)
      $display("FAIL rst_mid_state: busy=%b rdy=%b vld=%b p=%h want 0 1 0 000000",
               o_busy, o_in_rdy, o_out_vld, o_p);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (o_out_vld) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL rst_mid_no_output: got out_vld rise want none");
    else n_pass++;
    do_op(1'b0, 16'd2, 8'd3, 0, "post_rst");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      do_op(i[0], 16'($urandom), 8'($urandom), 0, "b2b");
    end
  endtask

  task automatic test_random();
    logic [15:0] av;
    logic [7:0] bv;
    for (int i = 0; i < 60; i++) begin
      av = 16'($urandom);
      bv = 8'($urandom);
      case ($urandom_range(0, 7))
        0: bv = 8'h00;
        1: bv = 8'h80;
        2: av = 16'h8000;
        default: ;
      endcase
      do_op(i[0], av, bv, $urandom_range(0, 3), "rand");
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
